// File: rtl/dbg_router.sv
// Debug request router: decodes a 14-bit debug address into one of three
// target segments, runs a single outstanding access with an ack timeout,
// and returns a registered response with an error flag.
module dbg_router #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [13:0] req_addr,
    input  logic        req_we,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [2:0]  tgt_sel,
    output logic [11:0] tgt_addr,
    output logic        tgt_we,
    output logic [7:0]  tgt_wdata,
    input  logic [2:0]  tgt_ack,
    input  logic [7:0]  tgt_rdata_ctl,
    input  logic [7:0]  tgt_rdata_rom,
    input  logic [7:0]  tgt_rdata_ram
);

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned NT = 3;
    localparam int unsigned CW = 8;

    localparam logic [1:0] SEG_CTL  = 2'd0;
    localparam logic [1:0] SEG_ROM  = 2'd1;
    localparam logic [1:0] SEG_RAM  = 2'd2;

    // Last wait-counter value of an ACCESS; the access lasts TIMEOUT_CYCLES cycles.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic [NT-1:0]   sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]   wait_q, wait_d;

    logic            sel_ack;
    logic [DW-1:0]   tgt_rdata_mux;

    // Only the selected target's ack counts; others are masked off.
    assign sel_ack = |(tgt_ack & sel_q);

    // Read data of the currently selected target.
    always_comb begin
        tgt_rdata_mux = '0;
        unique case (sel_q)
            3'b001:  tgt_rdata_mux = tgt_rdata_ctl;
            3'b010:  tgt_rdata_mux = tgt_rdata_rom;
            3'b100:  tgt_rdata_mux = tgt_rdata_ram;
            default: tgt_rdata_mux = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wait_d      = wait_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr[AW-1:0];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    wait_d  = '0;
                    unique case (req_addr[13:12])
                        SEG_CTL: begin
                            state_d = S_ACCESS;
                            sel_d   = 3'b001;
                        end
                        SEG_ROM: begin
                            state_d = S_ACCESS;
                            sel_d   = 3'b010;
                        end
                        SEG_RAM: begin
                            state_d = S_ACCESS;
                            sel_d   = 3'b100;
                        end
                        default: begin
                            // Reserved segment answers immediately with an error.
                            state_d     = S_RESP;
                            sel_d       = '0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b1;
                            rsp_rdata_d = '0;
                        end
                    endcase
                end
            end

            S_ACCESS: begin
                if (sel_ack) begin
                    // Ack wins over a timeout falling on the same cycle.
                    state_d     = S_RESP;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = we_q ? '0 : tgt_rdata_mux;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_RESP;
                    sel_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = S_IDLE;
                sel_d       = '0;
                rsp_valid_d = 1'b0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // Registered outputs and transaction context.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wait_q      <= '0;
        end else begin
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wait_q      <= wait_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign tgt_sel   = sel_q;
    assign tgt_addr  = addr_q;
    assign tgt_we    = we_q;
    assign tgt_wdata = wdata_q;

endmodule

// File: tb/tb_dbg_router.sv
// Directed bench for dbg_router: vector table of single transactions plus
// hand-written backpressure, late-ack and mid-transaction reset sequences.
module tb_dbg_router;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_addr;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [2:0]  tgt_sel;
    logic [11:0] tgt_addr;
    logic        tgt_we;
    logic [7:0]  tgt_wdata;
    logic [2:0]  tgt_ack;
    logic [7:0]  tgt_rdata_ctl;
    logic [7:0]  tgt_rdata_rom;
    logic [7:0]  tgt_rdata_ram;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbg_router #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_we        (req_we),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .tgt_sel       (tgt_sel),
        .tgt_addr      (tgt_addr),
        .tgt_we        (tgt_we),
        .tgt_wdata     (tgt_wdata),
        .tgt_ack       (tgt_ack),
        .tgt_rdata_ctl (tgt_rdata_ctl),
        .tgt_rdata_rom (tgt_rdata_rom),
        .tgt_rdata_ram (tgt_rdata_ram)
    );

    // ack_cyc: cycle after acceptance (1 = first cycle tgt_sel is up) in which
    // ack_bits are driven; exp_rsp: cycle after acceptance where rsp_valid is seen.
    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          ack_cyc;
        logic [2:0]  ack_bits;
        logic [2:0]  exp_sel;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_rsp;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request from a negedge in IDLE, follow it to completion.
    task automatic run_vec(input vec_t v, input int idx);
        int          got;
        logic [11:0] exp_addr;
        got      = 0;
        exp_addr = v.addr[11:0];
        chk($sformatf("v%0d_req_ready_idle", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (rsp_valid) begin
                got = c;
                break;
            end
            chk($sformatf("v%0d_c%0d_tgt_sel", idx, c), 32'(tgt_sel), 32'(v.exp_sel));
            chk($sformatf("v%0d_c%0d_tgt_addr", idx, c), 32'(tgt_addr), 32'(exp_addr));
            chk($sformatf("v%0d_c%0d_tgt_we", idx, c), 32'(tgt_we), 32'(v.we));
            chk($sformatf("v%0d_c%0d_tgt_wdata", idx, c), 32'(tgt_wdata), 32'(v.wdata));
            chk($sformatf("v%0d_c%0d_req_ready", idx, c), 32'(req_ready), 32'd0);
            tgt_ack = (c == v.ack_cyc) ? v.ack_bits : 3'b000;
            @(negedge clk);
        end
        tgt_ack = 3'b000;
        chk($sformatf("v%0d_rsp_cycle", idx), 32'(got), 32'(v.exp_rsp));
        chk($sformatf("v%0d_rsp_rdata", idx), 32'(rsp_rdata), 32'(v.exp_rdata));
        chk($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.exp_err));
        chk($sformatf("v%0d_resp_tgt_sel", idx), 32'(tgt_sel), 32'd0);
        chk($sformatf("v%0d_resp_req_ready", idx), 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk($sformatf("v%0d_done_rsp_valid", idx), 32'(rsp_valid), 32'd0);
        chk($sformatf("v%0d_done_req_ready", idx), 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        chk({tag, "_tgt_sel"},   32'(tgt_sel),   32'd0);
        chk({tag, "_tgt_addr"},  32'(tgt_addr),  32'd0);
        chk({tag, "_tgt_we"},    32'(tgt_we),    32'd0);
        chk({tag, "_tgt_wdata"}, 32'(tgt_wdata), 32'd0);
    endtask

    initial begin
        //          addr      we    wdata  ackc bits    sel     rdata  err  rsp
        vecs[0] = '{14'h0004, 1'b0, 8'h00, 3, 3'b001, 3'b001, 8'h5A, 1'b0, 4};
        vecs[1] = '{14'h2010, 1'b1, 8'hC3, 2, 3'b100, 3'b100, 8'h00, 1'b0, 3};
        vecs[2] = '{14'h3000, 1'b0, 8'h00, 0, 3'b000, 3'b000, 8'h00, 1'b1, 1};
        vecs[3] = '{14'h1ABC, 1'b0, 8'h00, 2, 3'b001, 3'b010, 8'h00, 1'b1, 5};
        vecs[4] = '{14'h1FFF, 1'b0, 8'h00, 4, 3'b010, 3'b010, 8'h3C, 1'b0, 5};
        vecs[5] = '{14'h2FFF, 1'b0, 8'h00, 1, 3'b111, 3'b100, 8'h96, 1'b0, 2};
        vecs[6] = '{14'h0ABC, 1'b1, 8'h7E, 1, 3'b001, 3'b001, 8'h00, 1'b0, 2};
        vecs[7] = '{14'h3FFF, 1'b1, 8'hFF, 0, 3'b000, 3'b000, 8'h00, 1'b1, 1};
        vecs[8] = '{14'h2123, 1'b0, 8'h00, 3, 3'b011, 3'b100, 8'h00, 1'b1, 5};

        rst_n         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_we        = 1'b0;
        req_wdata     = '0;
        rsp_ready     = 1'b0;
        tgt_ack       = 3'b000;
        tgt_rdata_ctl = 8'h5A;
        tgt_rdata_rom = 8'h3C;
        tgt_rdata_ram = 8'h96;

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: CTL read acked in first ACCESS cycle, consumer stalls 5 cycles.
        req_valid = 1'b1; req_addr = 14'h0004; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        tgt_ack = 3'b001;
        @(negedge clk);
        tgt_ack = 3'b000;
        req_valid = 1'b1; req_addr = 14'h2000;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_rsp_rdata", c), 32'(rsp_rdata), 32'h5A);
            chk($sformatf("bp%0d_rsp_err", c), 32'(rsp_err), 32'd0);
            chk($sformatf("bp%0d_req_ready", c), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_tgt_sel", c), 32'(tgt_sel), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_req_ready", 32'(req_ready), 32'd1);
        chk("bp_no_accept_on_complete", 32'(tgt_sel), 32'd0);
        @(negedge clk);

        // Timeout then late ack on the timed-out target, in RESP and in IDLE.
        req_valid = 1'b1; req_addr = 14'h1234; req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < int'(TO); c++) @(negedge clk);
        chk("late_timeout_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("late_timeout_rsp_err", 32'(rsp_err), 32'd1);
        tgt_ack = 3'b010;
        @(negedge clk);
        chk("late_resp_rsp_err", 32'(rsp_err), 32'd1);
        chk("late_resp_rsp_rdata", 32'(rsp_rdata), 32'd0);
        tgt_ack = 3'b000;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        tgt_ack = 3'b010;
        @(negedge clk);
        tgt_ack = 3'b000;
        chk("late_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_idle_req_ready", 32'(req_ready), 32'd1);

        // Reset mid-ACCESS abandons the transaction.
        req_valid = 1'b1; req_addr = 14'h2010; req_we = 1'b1; req_wdata = 8'hC3;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_access_tgt_sel", 32'(tgt_sel), 32'b100);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tgt_ack = 3'b100;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tgt_ack = 3'b000;
            chk($sformatf("post_reset%0d_rsp_valid", c), 32'(rsp_valid), 32'd0);
            chk($sformatf("post_reset%0d_req_ready", c), 32'(req_ready), 32'd1);
            chk($sformatf("post_reset%0d_tgt_sel", c), 32'(tgt_sel), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbg_router.md
DBG_ROUTER -- requirements
Module: dbg_router

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent waiting for a target ack (range 1..255).
REQ-002 The block SHALL have these ports:
- clk, input, 1: sole clock; all logic on the rising edge.
- rst_n, input, 1: reset; asynchronous and active-low.
- req_valid, input, 1: debug request valid.
- req_ready, output, 1: router can accept a request.
- req_addr, input, 14: debug address; [13:12] = segment (0 CTL, 1 ROM, 2 RAM, 3 RSVD), [11:0] = segment address.
- req_we, input, 1: 1 = write, 0 = read.
- req_wdata, input, 8: write data.
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: response consumer ready.
- rsp_rdata, output, 8: read data.
- rsp_err, output, 1: error flag (RSVD segment or timeout).
- tgt_sel, output, 3: one-hot target select; bit0 CTL, bit1 ROM, bit2 RAM.
- tgt_addr, output, 12: segment address to the target.
- tgt_we, output, 1: write strobe qualifier.
- tgt_wdata, output, 8: write data to the target.
- tgt_ack, input, 3: per-target completion, same bit order as tgt_sel.
- tgt_rdata_ctl, tgt_rdata_rom, tgt_rdata_ram, input, 8 each: per-target read data, valid with the matching ack bit.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS and RESP; only one transaction SHALL be outstanding at a time.
REQ-004 In IDLE, req_ready SHALL be 1; in ACCESS and RESP it SHALL be 0.
REQ-005 A request SHALL be accepted on a cycle with req_valid=1 and req_ready=1; the router then registers addr, we and wdata.
REQ-006 An accepted request with segment RSVD SHALL go directly to RESP, with rsp_err=1 and rsp_rdata=8'h00; no tgt_sel bit SHALL assert.
REQ-007 An accepted request with segment CTL/ROM/RAM SHALL go to ACCESS; tgt_sel SHALL be the matching one-hot value from the next cycle.
REQ-008 In ACCESS, tgt_sel, tgt_addr, tgt_we and tgt_wdata SHALL be held stable until the transaction ends.
REQ-009 Outside ACCESS, tgt_sel SHALL be 3'b000; tgt_addr, tgt_we and tgt_wdata are don't-care.
REQ-010 ACCESS SHALL end on the first cycle in which the tgt_ack bit of the selected target is 1; ack bits of non-selected targets SHALL be ignored.
REQ-011 On ack, the router SHALL capture rsp_rdata and go to RESP with rsp_err=0:
- read: rsp_rdata = the selected target's rdata.
- write: rsp_rdata = 8'h00.
REQ-012 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-013 If the wait counter reaches TIMEOUT_CYCLES without ack, the router SHALL go to RESP with rsp_err=1 and rsp_rdata=8'h00.
REQ-014 If ack and timeout fall on the same cycle, ack SHALL win (rsp_err=0).
REQ-015 Latency:
- Request accepted at cycle N: tgt_sel asserts at N+1.
- Ack sampled at cycle M: rsp_valid asserts at M+1.
- RSVD request accepted at N: rsp_valid asserts at N+1.
REQ-016 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; the FSM then returns to IDLE on the next cycle.
REQ-017 A new request SHALL NOT be accepted in the same cycle a response completes.
REQ-018 Late acks arriving after a timeout SHALL be ignored.

Reset
REQ-019 While rst_n=0, the block SHALL force:
- state = IDLE
- req_ready = 1
- rsp_valid = 0
- rsp_rdata = 8'h00
- rsp_err = 0
- tgt_sel = 3'b000
- tgt_addr = 0, tgt_we = 0, tgt_wdata = 0
- wait counter = 0
REQ-020 Reset asserted mid-transaction (ACCESS or RESP) SHALL abandon the transaction; no response SHALL be emitted after reset release.

Verification
REQ-021 CTL read: addr 14'h0004, we=0; tgt_sel=001 at N+1; ack[0] with rdata_ctl=8'h5A two cycles later -> rsp_valid with rsp_rdata=8'h5A, rsp_err=0.
REQ-022 RAM write: addr 14'h2010, wdata=8'hC3 -> tgt_sel=100, tgt_addr=12'h010, tgt_we=1, tgt_wdata=8'hC3 held until ack[2] -> rsp_rdata=8'h00, rsp_err=0.
REQ-023 RSVD: addr 14'h3000 -> rsp_valid at N+1 with rsp_err=1; tgt_sel stays 000 throughout.
REQ-024 Timeout and wrong ack: TIMEOUT_CYCLES=4, ROM read, only ack[0] pulsed -> rsp_err=1, rsp_rdata=8'h00; a later ack[1] is ignored.
REQ-025 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable and req_ready=0 throughout; rsp_ready=1 -> req_ready=1 the cycle after.
REQ-026 Reset mid-ACCESS: rst_n pulsed low -> outputs immediately take their reset values; after release, req_ready=1 and no spurious rsp_valid appears.
